// File: rtl/rx_frame_stats.sv
// rx_frame_stats: receive-side frame statistics collector.
// Sinks an AXI-Stream frame feed, accumulates per-frame byte length and
// updates saturating good/bad/runt/oversize counters plus a 64-bit good byte
// total. All statistics are exposed through a small AXI-lite register bank.
module rx_frame_stats #(
  parameter int DATA_WIDTH      = 64,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int MIN_FRAME_LEN   = 60,
  parameter int MAX_FRAME_LEN   = 1514
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tuser,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [31:0]                s_axil_wdata,
  input  logic [3:0]                 s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [31:0]                s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] k);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < KEEP_W; i++) c = c + 16'(k[i]);
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] a);
    return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
  endfunction

  function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [15:0] b);
    logic [64:0] s;
    s = {1'b0, a} + 65'(b);
    return s[64] ? {64{1'b1}} : s[63:0];
  endfunction

  logic [15:0] run_len;
  logic        vld_p1;
  logic [15:0] len_p1;
  logic        bad_p1;
  logic [31:0] good_cnt, bad_cnt, runt_cnt, over_cnt;
  logic [63:0] byte_cnt;
  logic [31:0] shadow_hi;
  logic [15:0] last_len;
  logic [31:0] rd_mux;

  // Stage p0: beat acceptance and running length
  logic        beat_p0, done_p0;
  logic [15:0] len_next_p0;
  assign s_axis_tready = rst_n;
  assign beat_p0       = s_axis_tvalid & s_axis_tready;
  assign done_p0       = beat_p0 & s_axis_tlast;
  assign len_next_p0   = sat_add16(run_len, popcount(s_axis_tkeep));

  logic wr_hs, rd_hs, clr;
  assign s_axil_awready = rst_n & s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid;
  assign s_axil_wready  = s_axil_awready;
  assign s_axil_arready = rst_n & ~s_axil_rvalid;
  assign wr_hs  = s_axil_awready;
  assign rd_hs  = s_axil_arvalid & s_axil_arready;
  assign clr    = wr_hs & (s_axil_awaddr[4:2] == 3'd7) & s_axil_wdata[0] & s_axil_wstrb[0];
  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;

  logic unused_ok;
  assign unused_ok = ^{s_axis_tdata, s_axil_awaddr, s_axil_awprot, s_axil_wdata,
                       s_axil_wstrb, s_axil_araddr, s_axil_arprot};

  // Running frame length, restarted after each tlast beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       run_len <= '0;
    else if (clr)     run_len <= '0;
    else if (beat_p0) run_len <= s_axis_tlast ? 16'd0 : len_next_p0;
  end

  // Stage p1: completed-frame pipeline register; a clear kills the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      len_p1 <= '0;
      bad_p1 <= 1'b0;
    end else begin
      vld_p1 <= done_p0 & ~clr;
      len_p1 <= len_next_p0;
      bad_p1 <= s_axis_tuser;
    end
  end

  // Statistics update from the p1 stage; clear overrides a pending update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0; bad_cnt <= '0; runt_cnt <= '0; over_cnt <= '0;
      byte_cnt <= '0; last_len <= '0;
    end else if (clr) begin
      good_cnt <= '0; bad_cnt <= '0; runt_cnt <= '0; over_cnt <= '0;
      byte_cnt <= '0; last_len <= '0;
    end else if (vld_p1) begin
      if (bad_p1) begin
        bad_cnt <= sat_inc32(bad_cnt);
      end else begin
        good_cnt <= sat_inc32(good_cnt);
        byte_cnt <= sat_add64(byte_cnt, len_p1);
      end
      if (len_p1 < 16'(MIN_FRAME_LEN)) runt_cnt <= sat_inc32(runt_cnt);
      if (len_p1 > 16'(MAX_FRAME_LEN)) over_cnt <= sat_inc32(over_cnt);
      last_len <= len_p1;
    end
  end

  // Upper byte-total word captured when the low word is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   shadow_hi <= '0;
    else if (clr) shadow_hi <= '0;
    else if (rd_hs && s_axil_araddr[4:2] == 3'd2) shadow_hi <= byte_cnt[63:32];
  end

  // Read data selection from current (pre-update) register values
  always_comb begin
    rd_mux = '0;
    case (s_axil_araddr[4:2])
      3'd0: rd_mux = good_cnt;
      3'd1: rd_mux = bad_cnt;
      3'd2: rd_mux = byte_cnt[31:0];
      3'd3: rd_mux = shadow_hi;
      3'd4: rd_mux = runt_cnt;
      3'd5: rd_mux = over_cnt;
      3'd6: rd_mux = {16'h0000, last_len};
      default: rd_mux = '0;
    endcase
  end

  // Read response channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
    end else if (rd_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_mux;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

  // Write response channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              s_axil_bvalid <= 1'b0;
    else if (wr_hs)          s_axil_bvalid <= 1'b1;
    else if (s_axil_bready)  s_axil_bvalid <= 1'b0;
  end

endmodule

// File: tb/tb_rx_frame_stats.sv
// Testbench for rx_frame_stats: directed scenarios plus randomized frames,
// compared against a frame-level statistics model.
module tb_rx_frame_stats;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tvalid = 1'b0, tready, tlast = 1'b0, tuser = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 1'b1, arvalid = 1'b0, arready, rvalid, rready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_good, m_bad, m_runt, m_over;
  logic [63:0] m_bytes;
  logic [15:0] m_last;

  always #5 clk = ~clk;

  rx_frame_stats dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
    .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_good = '0; m_bad = '0; m_runt = '0; m_over = '0; m_bytes = '0; m_last = '0;
  endtask

  task automatic model_frame(input int len, input bit bad);
    int l;
    l = (len > 65535) ? 65535 : len;
    if (bad) begin
      if (m_bad != 32'hFFFF_FFFF) m_bad++;
    end else begin
      if (m_good != 32'hFFFF_FFFF) m_good++;
      if (m_bytes > 64'hFFFF_FFFF_FFFF_FFFF - 64'(l)) m_bytes = '1;
      else m_bytes = m_bytes + 64'(l);
    end
    if (l < 60) m_runt++;
    if (l > 1514) m_over++;
    m_last = 16'(l);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // mode: 0 drop tvalid afterwards, 1 leave for back-to-back,
  //       2 clear write on the tlast beat, 3 clear write the cycle after
  task automatic send_frame(input int len, input bit bad, input bit rnd, input int mode);
    int rem, cnt, pc, b;
    logic [7:0] k;
    rem = len;
    while (rem > 0) begin
      cnt = (rem < 8) ? rem : 8;
      if (rnd) cnt = $urandom_range(1, cnt);
      k = '0; pc = 0;
      if (rnd) begin
        while (pc < cnt) begin
          b = $urandom_range(0, 7);
          if (!k[b]) begin k[b] = 1'b1; pc++; end
        end
      end else begin
        for (int i = 0; i < cnt; i++) k[i] = 1'b1;
      end
      rem -= cnt;
      @(negedge clk);
      tvalid = 1'b1; tkeep = k; tdata = {$urandom, $urandom};
      tlast = (rem == 0); tuser = (rem == 0) ? bad : 1'b0;
      if (rem == 0 && mode == 2) begin
        awaddr = 32'h1C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1 check_val("clr_on_last_awready", 64'(awready), 64'd1);
      end
    end
    if (mode == 0) idle(0);
    if (mode == 2) begin
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    end
    if (mode == 3) begin
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      awaddr = 32'h1C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      #1 check_val("clr_after_last_awready", 64'(awready), 64'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    #1;
    while (!awready && t < 20) begin @(negedge clk); #1; t++; end
    if (t >= 20) check_val("aw_timeout", 64'd0, 64'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) check_val("b_timeout", 64'd0, 64'd1);
    check_val("bresp", 64'(bresp), 64'd0);
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
    int t;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    t = 0;
    #1;
    while (!arready && t < 20) begin @(negedge clk); #1; t++; end
    if (t >= 20) check_val("ar_timeout", 64'd0, 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) check_val("r_timeout", 64'd0, 64'd1);
    d = rdata;
    check_val("rresp", 64'(rresp), 64'd0);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d, lo;
    idle(3);
    axil_read(32'h00, d); check_val({tag, "_good"}, 64'(d), 64'(m_good));
    axil_read(32'h04, d); check_val({tag, "_bad"}, 64'(d), 64'(m_bad));
    axil_read(32'h08, lo);
    axil_read(32'h0C, d); check_val({tag, "_bytes"}, {d, lo}, m_bytes);
    axil_read(32'h10, d); check_val({tag, "_runt"}, 64'(d), 64'(m_runt));
    axil_read(32'h14, d); check_val({tag, "_over"}, 64'(d), 64'(m_over));
    axil_read(32'h18, d); check_val({tag, "_last"}, 64'(d), 64'(m_last));
    axil_read(32'h3C, d); check_val({tag, "_ctrl"}, 64'(d), 64'd0);
  endtask

  task automatic do_clear();
    axil_write(32'h1C, 32'h1, 4'h1);
    model_clear();
  endtask

  initial begin
    logic [31:0] d;
    int len, gap;
    bit bad;
    model_clear();
    #1;
    check_val("rst_tready", 64'(tready), 64'd0);
    check_val("rst_arready", 64'(arready), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("post_rst_tready", 64'(tready), 64'd1);
    check_all("reset");

    send_frame(64, 0, 0, 0); model_frame(64, 0);
    check_all("good64");

    // writes that must not clear: wrong offset, wdata[0]=0, wstrb[0]=0
    axil_write(32'h00, 32'h1, 4'hF);
    axil_write(32'h1C, 32'h2, 4'hF);
    axil_write(32'h1C, 32'h1, 4'hE);
    check_all("noclear");

    do_clear(); check_all("clear");

    send_frame(59, 1, 0, 0); model_frame(59, 1);
    check_all("bad59");

    do_clear();
    send_frame(1515, 0, 0, 1); model_frame(1515, 0);
    send_frame(60, 0, 0, 0);   model_frame(60, 0);
    check_all("b2b");

    do_clear();
    @(negedge clk); force dut.good_cnt = 32'hFFFF_FFFE;
    @(negedge clk); release dut.good_cnt;
    m_good = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin send_frame(100, 0, 0, 0); model_frame(100, 0); end
    check_all("good_sat");

    // coherent 64-bit read across a carry into the upper word
    @(negedge clk); force dut.byte_cnt = 64'h0000_0000_FFFF_FFF0;
    @(negedge clk); release dut.byte_cnt;
    m_bytes = 64'h0000_0000_FFFF_FFF0;
    axil_read(32'h08, d); check_val("shadow_lo0", 64'(d), 64'hFFFF_FFF0);
    send_frame(64, 0, 1, 0); model_frame(64, 0);
    idle(3);
    axil_read(32'h0C, d); check_val("shadow_hold", 64'(d), 64'd0);
    check_all("shadow_new");

    @(negedge clk); force dut.byte_cnt = 64'hFFFF_FFFF_FFFF_FFF5;
    @(negedge clk); release dut.byte_cnt;
    m_bytes = 64'hFFFF_FFFF_FFFF_FFF5;
    send_frame(64, 0, 0, 0); model_frame(64, 0);
    check_all("bytes_sat");

    send_frame(64, 0, 0, 2); model_clear();
    check_all("clr_on_tlast");
    send_frame(64, 0, 0, 0); model_frame(64, 0);
    send_frame(70, 1, 0, 3); model_clear();
    check_all("clr_pending");

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0: len = 59;
        1: len = 60;
        2: len = 1514;
        3: len = 1515;
        default: len = $urandom_range(1, 1600);
      endcase
      bad = ($urandom_range(0, 3) == 0);
      gap = (i == 24) ? 1 : $urandom_range(0, 2);
      send_frame(len, bad, 1, (gap == 0) ? 1 : 0);
      model_frame(len, bad);
      if (gap > 1) idle(gap - 1);
      if (i % 8 == 7) check_all("rand");
    end
    check_all("rand_end");

    send_frame(66000, 0, 0, 0); model_frame(66000, 0);
    check_all("len_sat");

    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tvalid = 1'b1; tkeep = 8'hFF; tlast = 1'b0; tuser = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0; tvalid = 1'b0;
    #1 check_val("midrst_tready", 64'(tready), 64'd0);
    check_val("midrst_arready", 64'(arready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    send_frame(16, 0, 0, 0); model_frame(16, 0);
    idle(2);
    check_val("midrst_bvalid", 64'(bvalid), 64'd0);
    check_val("midrst_rvalid", 64'(rvalid), 64'd0);
    check_all("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
